// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: command encodings and payload layout.
package alu_pkg;

    typedef enum logic [2:0] {
        CMD_ADD  = 3'd0,
        CMD_SUB  = 3'd1,
        CMD_XOR  = 3'd2,
        CMD_SLT  = 3'd3,
        CMD_AND  = 3'd4,
        CMD_NAND = 3'd5,
        CMD_NOR  = 3'd6,
        CMD_OR   = 3'd7
    } alu_cmd_e;

    localparam int unsigned ALU_MSB_DEFAULT = 31;

    // Payload is {result, carryout, overflow, zero}; flags occupy the low bits.
    localparam int unsigned FLAG_W     = 3;
    localparam int unsigned ZERO_BIT   = 0;
    localparam int unsigned OVF_BIT    = 1;
    localparam int unsigned CARRY_BIT  = 2;

    function automatic int unsigned payload_w(input int unsigned msb);
        return msb + 1 + FLAG_W;
    endfunction

endpackage

// File: rtl/alu_skid_buffer.sv
// Two-entry valid/ready buffer (output register plus skid register), strict FIFO order.
module alu_skid_buffer #(
    parameter int unsigned Width = 35
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Width-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width-1:0] out_data
);

    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [Width-1:0] out_data_q, out_data_d;
    logic [Width-1:0] skid_data_q, skid_data_d;
    logic             in_fire, out_fire;

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready = !skid_valid_q && !reset;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        out_data_d   = out_data_q;
        skid_data_d  = skid_data_q;
        if (out_fire || !out_valid_q) begin
            if (skid_valid_q) begin
                out_data_d   = skid_data_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_data_d  = in_data;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_data_d  = in_data;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_data_q   <= '0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_data_q   <= out_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: selects a bitslice result, derives SLT and qualified flags,
// buffers the payload through a skid buffer and counts signed-overflow events.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int unsigned n     = ALU_MSB_DEFAULT,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       command,
    input  logic [n:0]       add_result,
    input  logic             add_carryout,
    input  logic             add_overflow,
    input  logic [n:0]       xor_result,
    input  logic [n:0]       and_result,
    input  logic [n:0]       nand_result,
    input  logic [n:0]       nor_result,
    input  logic [n:0]       or_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [n:0]       result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             count_clear
);

    localparam int unsigned PayloadW = payload_w(n);
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [n:0]          sel_result;
    logic                sel_carry, sel_ovf, sel_zero, slt_bit, is_arith;
    logic [PayloadW-1:0] in_payload, out_payload;
    logic                accept;
    logic [CNT_W-1:0]    ovf_count_q, ovf_count_d;

    // Sign of a-b corrected by overflow gives the true signed less-than.
    assign slt_bit = add_result[n] ^ add_overflow;

    always_comb begin
        sel_result = '0;
        is_arith   = 1'b0;
        unique case (alu_cmd_e'(command))
            CMD_ADD, CMD_SUB: begin
                sel_result = add_result;
                is_arith   = 1'b1;
            end
            CMD_SLT:  sel_result = {{n{1'b0}}, slt_bit};
            CMD_XOR:  sel_result = xor_result;
            CMD_AND:  sel_result = and_result;
            CMD_NAND: sel_result = nand_result;
            CMD_NOR:  sel_result = nor_result;
            CMD_OR:   sel_result = or_result;
        endcase
    end

    assign sel_carry  = is_arith && add_carryout;
    assign sel_ovf    = is_arith && add_overflow;
    assign sel_zero   = (sel_result == '0);
    assign in_payload = {sel_result, sel_carry, sel_ovf, sel_zero};

    alu_skid_buffer #(
        .Width (PayloadW)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_payload)
    );

    assign result   = out_payload[PayloadW-1:FLAG_W];
    assign carryout = out_payload[CARRY_BIT];
    assign overflow = out_payload[OVF_BIT];
    assign zero     = out_payload[ZERO_BIT];

    assign accept = in_valid && in_ready;

    always_comb begin
        ovf_count_d = ovf_count_q;
        if (count_clear) begin
            ovf_count_d = '0;
        end else if (accept && sel_ovf && (ovf_count_q != CntMax)) begin
            ovf_count_d = ovf_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_count_q <= '0;
        end else begin
            ovf_count_q <= ovf_count_d;
        end
    end

    assign ovf_count = ovf_count_q;

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

- Registered output stage directly downstream of the ALU bitslice modules (ADD/SUB adder, XOR, AND, NAND, NOR, OR).
- Per accepted command, selects one bitslice result, derives SLT, computes `zero`, and qualifies `carryout`/`overflow`.
- Presents the result on a valid/ready interface through a 2-entry skid buffer and keeps a saturating signed-overflow event counter.
- Replaces the bitslices' tied-off flag outputs with real, command-qualified flags.

## Interface

**Parameters**
- `n`, default 31: MSB index. Data width is n+1, matching the bitslice convention.
- `CNT_W`, default 8: width of the overflow event counter.

**Ports** (clock and reset first)
- `clk` input 1: the single clock. All state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: command and bitslice results are valid this cycle.
- `in_ready` output 1: stage can accept this cycle.
- `command` input 3: ADD=0, SUB=1, XOR=2, SLT=3, AND=4, NAND=5, NOR=6, OR=7.
- `add_result` input n+1: adder bitslice sum. Upstream drives the adder with subtract=1 for SUB and SLT.
- `add_carryout` input 1: adder carry out.
- `add_overflow` input 1: adder signed overflow.
- `xor_result`, `and_result`, `nand_result`, `nor_result`, `or_result` input n+1 each: logic bitslice results.
- `out_valid` output 1: output holds a result.
- `out_ready` input 1: downstream consumes when out_valid && out_ready.
- `result` output n+1: selected result.
- `carryout` output 1: add_carryout for ADD/SUB, else 0.
- `overflow` output 1: add_overflow for ADD/SUB, else 0.
- `zero` output 1: 1 iff result == 0, for every command.
- `ovf_count` output CNT_W: saturating count of accepted ADD/SUB with overflow=1.
- `count_clear` input 1: clears ovf_count.

## Operation

**Accept and select**
- A command is accepted when in_valid && in_ready. Input is ignored otherwise.
- result per command:
  - ADD/SUB: add_result.
  - SLT: bit 0 = add_result[n] ^ add_overflow; bits n:1 = 0.
  - XOR/AND/NAND/NOR/OR: the matching bus.
- carryout and overflow are forced to 0 for SLT and all logic commands.
- zero is computed on the selected result before registering.

**Buffering** (payload = result, carryout, overflow, zero)
- Two entries: output register (OUT) and skid register (SKID).
- in_ready = !skid_valid, taken from a registered flag, so it is not combinational from out_ready.
- Accepted payload goes to OUT if OUT is empty or is being consumed this cycle; otherwise it goes to SKID.
- When OUT is consumed and SKID is valid, SKID moves into OUT and SKID empties. No accept can happen that cycle, since in_ready=0.
- Order is strictly FIFO.

**Occupancy states**
- EMPTY (out_valid=0): accept → ONE.
- ONE:
  - consume without accept → EMPTY.
  - accept without consume → FULL.
  - consume with accept → ONE, holding the new payload.
- FULL (in_ready=0): consume → ONE.

**Overflow counter**
- Increments on each accepted ADD or SUB with add_overflow=1.
- Saturates at 2^CNT_W−1.
- count_clear sets it to 0 and wins over a same-cycle increment.
- Counting is independent of out_ready.

## Timing

**Reset**
- While reset=1 at a clock edge: out_valid=0, skid empty, result=0, carryout=0, overflow=0, zero=0, ovf_count=0.
- in_ready=0 while reset is asserted; in_ready=1 the first cycle after.

**Latency and throughput**
- One cycle: accepted at edge k, out_valid=1 with that payload after edge k.
- Throughput is one result per cycle while out_ready is held 1.

**Backpressure**
- out_ready=0 for two accepts → FULL, in_ready=0 from the next cycle.
- OUT payload stays stable while out_valid && !out_ready.

**Reset mid-operation**
- Both entries are discarded with no output. The counter is cleared.

## Structure

- Shared package `alu_pkg`:
  - command encodings CMD_ADD … CMD_OR (3-bit);
  - default width localparam (31);
  - payload field widths.
- One sub-module, `alu_skid_buffer`: parameterised-width 2-entry valid/ready buffer holding the packed payload.
- Select, SLT, zero logic and the counter live in the top.

## Test plan

- **Reset release:** reset=1 for 2 cycles, then 0 → out_valid=0, in_ready=0 during reset, in_ready=1 after, ovf_count=0.
- **ADD:** command=ADD, add_result=0x00000000, add_carryout=1, add_overflow=0 → next cycle result=0, zero=1, carryout=1, overflow=0.
- **SLT and logic flags:**
  - SLT, add_result=0x80000000, add_overflow=1 → result=0, zero=1.
  - SLT, add_result=0xFFFFFFFF, add_overflow=0 → result=1, zero=0.
  - AND with add_carryout=1 → carryout=0.
- **Backpressure:** out_ready=0, three back-to-back accept attempts with XOR results 0x1, 0x2, 0x3 → only 0x1 and 0x2 accepted, in_ready=0 after the second. Then out_ready=1 → outputs 0x1, 0x2 in order, in_ready=1 again.
- **Counter:**
  - With CNT_W=2: five ADD with overflow=1 → ovf_count 1, 2, 3, 3, 3.
  - Overflow SUB together with count_clear → ovf_count=0.
  - SLT with overflow=1 → no increment.
- **Mid-operation reset:** reset while FULL → next cycle out_valid=0, ovf_count=0. The following accept appears with 1-cycle latency.
